// File: rtl/vfu_cfu_arbiter.sv
// Shares one VFU CFU slave port between N_REQ requesters and routes responses back in order.
// Latency: request path is combinational (0 cycles); responses are routed in the same cycle they arrive.
// Backpressure: req_ready follows vfu_req_ready; stalls at MAX_OUTSTANDING in flight; responses cannot be backpressured.

module vfu_cfu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_vld & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage is cleared too so the head reads as zero straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module vfu_cfu_arbiter #(
    parameter int N_REQ           = 2,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*32-1:0]   req_insn,
    input  logic [N_REQ*32-1:0]   req_data0,
    input  logic [N_REQ*32-1:0]   req_data1,
    input  logic [N_REQ*ID_W-1:0] req_id,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  vfu_req_valid,
    input  logic                  vfu_req_ready,
    output logic [31:0]           vfu_req_insn,
    output logic [31:0]           vfu_req_data0,
    output logic [31:0]           vfu_req_data1,
    input  logic                  vfu_resp_valid,
    input  logic [31:0]           vfu_resp_data,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  err
);

    localparam int SRC_W = $clog2(N_REQ);

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [ID_W-1:0]  id;
    } trk_t;

    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] cand;
    logic             cand_vld;
    logic [ID_W-1:0]  cand_id;
    logic             blocked;
    logic             accept;
    logic             resp_pop;
    logic             fifo_full;
    logic             fifo_empty;
    trk_t             push_ent;
    trk_t             head_ent;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx      = 0;
        cand     = '0;
        cand_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!cand_vld && req_valid[idx]) begin
                cand_vld = 1'b1;
                cand     = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        vfu_req_insn  = '0;
        vfu_req_data0 = '0;
        vfu_req_data1 = '0;
        cand_id       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cand_vld && (cand == SRC_W'(i))) begin
                vfu_req_insn  = req_insn[32*i +: 32];
                vfu_req_data0 = req_data0[32*i +: 32];
                vfu_req_data1 = req_data1[32*i +: 32];
                cand_id       = req_id[ID_W*i +: ID_W];
            end
        end
    end

    // Blocking looks only at the registered count so vfu_resp_valid never reaches req_ready.
    assign blocked       = fifo_full | rst;
    assign vfu_req_valid = cand_vld & ~blocked;
    assign accept        = vfu_req_valid & vfu_req_ready;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = cand_vld && (cand == SRC_W'(i)) && vfu_req_ready && !blocked;
        end
    end

    assign push_ent.src = cand;
    assign push_ent.id  = cand_id;
    assign resp_pop     = vfu_resp_valid & ~fifo_empty;

    vfu_cfu_fifo #(
        .WIDTH ($bits(trk_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_trk_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (accept),
        .push_dat (push_ent),
        .pop_vld  (resp_pop),
        .head_dat (head_ent),
        .count    (outstanding),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = resp_pop && !rst && (head_ent.src == SRC_W'(i));
        end
    end

    assign resp_id   = head_ent.id;
    assign resp_data = vfu_resp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            err <= 1'b0;
        end else begin
            if (accept) begin
                ptr <= (cand == SRC_W'(N_REQ - 1)) ? '0 : cand + SRC_W'(1);
            end
            if (vfu_resp_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vfu_cfu_arbiter.sv
// Randomized and directed checks of vfu_cfu_arbiter against a queue-based reference model.
module tb_vfu_cfu_arbiter;

    localparam int N     = 2;
    localparam int ID_W  = 4;
    localparam int MAX   = 8;
    localparam int CNT_W = $clog2(MAX) + 1;

    logic                clk;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*32-1:0]     req_insn;
    logic [N*32-1:0]     req_data0;
    logic [N*32-1:0]     req_data1;
    logic [N*ID_W-1:0]   req_id;
    logic [N-1:0]        resp_valid;
    logic [31:0]         resp_data;
    logic [ID_W-1:0]     resp_id;
    logic                vfu_req_valid;
    logic                vfu_req_ready;
    logic [31:0]         vfu_req_insn;
    logic [31:0]         vfu_req_data0;
    logic [31:0]         vfu_req_data1;
    logic                vfu_resp_valid;
    logic [31:0]         vfu_resp_data;
    logic [CNT_W-1:0]    outstanding;
    logic                err;

    vfu_cfu_arbiter #(
        .N_REQ           (N),
        .ID_W            (ID_W),
        .MAX_OUTSTANDING (MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_insn       (req_insn),
        .req_data0      (req_data0),
        .req_data1      (req_data1),
        .req_id         (req_id),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_id        (resp_id),
        .vfu_req_valid  (vfu_req_valid),
        .vfu_req_ready  (vfu_req_ready),
        .vfu_req_insn   (vfu_req_insn),
        .vfu_req_data0  (vfu_req_data0),
        .vfu_req_data1  (vfu_req_data1),
        .vfu_resp_valid (vfu_resp_valid),
        .vfu_resp_data  (vfu_resp_data),
        .outstanding    (outstanding),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int src;
        int id;
    } ent_t;

    ent_t          q[$];
    int            m_ptr;
    bit            m_err;
    int            n_tests;
    int            n_fail;
    logic [N-1:0]  acc_vec;

    logic [N-1:0]       s_ready;
    logic [N-1:0]       s_rv;
    logic [ID_W-1:0]    s_rid;
    logic [31:0]        s_rdata;
    logic [CNT_W-1:0]   s_out;
    logic               s_err;
    logic               s_vv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        req_valid      = '0;
        req_insn       = '0;
        req_data0      = '0;
        req_data1      = '0;
        req_id         = '0;
        vfu_req_ready  = 1'b1;
        vfu_resp_valid = 1'b0;
        vfu_resp_data  = '0;
    endtask

    task automatic set_req(input int i, input logic [31:0] insn, input logic [ID_W-1:0] id);
        req_valid[i]           = 1'b1;
        req_insn[32*i +: 32]   = insn;
        req_data0[32*i +: 32]  = insn ^ 32'h1111_0000;
        req_data1[32*i +: 32]  = insn ^ 32'h0000_2222;
        req_id[ID_W*i +: ID_W] = id;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model over the edge.
    task automatic tick();
        int            cand;
        int            idx;
        logic [N-1:0]  e_ready;
        logic [N-1:0]  e_rv;
        logic          e_vv;
        logic [31:0]   e_insn;
        logic [31:0]   e_d0;
        logic [31:0]   e_d1;
        ent_t          e;
        @(negedge clk);
        s_ready = req_ready;
        s_rv    = resp_valid;
        s_rid   = resp_id;
        s_rdata = resp_data;
        s_out   = outstanding;
        s_err   = err;
        s_vv    = vfu_req_valid;
        acc_vec = '0;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_vfu_valid", vfu_req_valid, 0);
            chk("rst_resp_valid", resp_valid, 0);
        end else begin
            chk("outstanding", outstanding, q.size());
            chk("err", err, m_err);
            cand = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (cand < 0 && req_valid[idx]) cand = idx;
            end
            e_vv    = (cand >= 0) && (q.size() != MAX);
            e_ready = '0;
            if (e_vv && vfu_req_ready) e_ready[cand] = 1'b1;
            e_insn = '0;
            e_d0   = '0;
            e_d1   = '0;
            if (cand >= 0) begin
                e_insn = req_insn[32*cand +: 32];
                e_d0   = req_data0[32*cand +: 32];
                e_d1   = req_data1[32*cand +: 32];
            end
            e_rv = '0;
            if (vfu_resp_valid && q.size() > 0) e_rv[q[0].src] = 1'b1;
            chk("vfu_req_valid", vfu_req_valid, e_vv);
            chk("req_ready", req_ready, e_ready);
            chk("vfu_req_insn", vfu_req_insn, e_insn);
            chk("vfu_req_data0", vfu_req_data0, e_d0);
            chk("vfu_req_data1", vfu_req_data1, e_d1);
            chk("resp_valid", resp_valid, e_rv);
            chk("resp_data", resp_data, vfu_resp_data);
            if (e_rv != '0) chk("resp_id", resp_id, q[0].id);
            if (vfu_resp_valid) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1'b1;
            end
            if (e_vv && vfu_req_ready) begin
                e.src = cand;
                e.id  = int'(req_id[ID_W*cand +: ID_W]);
                q.push_back(e);
                m_ptr   = (cand + 1) % N;
                acc_vec = e_ready;
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        while (q.size() > 0) begin
            vfu_resp_valid = 1'b1;
            vfu_resp_data  = $urandom();
            tick();
        end
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ptr   = 0;
        m_err   = 1'b0;
        acc_vec = '0;
        rst     = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_vfu_valid", vfu_req_valid, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_resp_id", resp_id, 0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester round trip.
        set_req(0, 32'h0000_0057, 4'd3);
        tick();
        chk("t1_ready", s_ready, 2'b01);
        chk("t1_vfu_valid", s_vv, 1);
        idle();
        vfu_resp_valid = 1'b1;
        vfu_resp_data  = 32'hDEAD_BEEF;
        tick();
        chk("t1_out_before", s_out, 1);
        chk("t1_resp_valid", s_rv, 2'b01);
        chk("t1_resp_id", s_rid, 3);
        chk("t1_resp_data", s_rdata, 32'hDEAD_BEEF);
        idle();
        tick();
        chk("t1_out_after", s_out, 0);

        // Fairness with both requesters always valid.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 32'h100 + k, 4'd1);
            set_req(1, 32'h200 + k, 4'd2);
            tick();
            chk("t2_grant", s_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            vfu_resp_valid = 1'b1;
            vfu_resp_data  = 32'hA000 + k;
            tick();
            chk("t2_resp_src", s_rv, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_resp_id", s_rid, (k % 2 == 0) ? 1 : 2);
        end
        idle();

        // Full stall; a same-cycle response must not unblock.
        do_reset();
        for (int k = 0; k < MAX; k++) begin
            set_req(0, 32'h300 + k, ID_W'(k));
            tick();
        end
        set_req(0, 32'h3FF, 4'hF);
        vfu_resp_valid = 1'b1;
        tick();
        chk("t3_full_out", s_out, MAX);
        chk("t3_full_ready", s_ready, 0);
        vfu_resp_valid = 1'b0;
        tick();
        chk("t3_next_ready", s_ready, 2'b01);
        chk("t3_next_out", s_out, MAX - 1);
        drain();

        // VFU backpressure with req1 waiting.
        do_reset();
        set_req(1, 32'h0000_4057, 4'd6);
        vfu_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_stall_ready", s_ready, 0);
            chk("t4_stall_out", s_out, 0);
        end
        vfu_req_ready = 1'b1;
        tick();
        chk("t4_accept", s_ready, 2'b10);
        drain();

        // Push and pop together at outstanding == 1.
        do_reset();
        set_req(0, 32'h500, 4'd5);
        tick();
        set_req(0, 32'h501, 4'd9);
        vfu_resp_valid = 1'b1;
        tick();
        chk("t5_out_pushpop", s_out, 1);
        chk("t5_first_id", s_rid, 5);
        idle();
        vfu_resp_valid = 1'b1;
        tick();
        chk("t5_out_held", s_out, 1);
        chk("t5_newer_id", s_rid, 9);
        idle();
        tick();
        chk("t5_out_empty", s_out, 0);

        // Response with nothing outstanding, then reset clears err and ptr.
        do_reset();
        vfu_resp_valid = 1'b1;
        tick();
        chk("t6_no_resp", s_rv, 0);
        idle();
        tick();
        chk("t6_err_set", s_err, 1);
        chk("t6_out_zero", s_out, 0);
        do_reset();
        set_req(0, 32'h600, 4'd1);
        set_req(1, 32'h601, 4'd2);
        tick();
        chk("t6_err_clear", s_err, 0);
        chk("t6_ptr_zero", s_ready, 2'b01);
        drain();

        // Randomized traffic, honouring the hold-while-stalled rule.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc_vec[i])) begin
                    if ($urandom_range(0, 99) < 60) set_req(i, $urandom(), ID_W'($urandom()));
                    else req_valid[i] = 1'b0;
                end
            end
            vfu_req_ready = ($urandom_range(0, 99) < 75);
            if (q.size() > 0) vfu_resp_valid = ($urandom_range(0, 99) < 40);
            else vfu_resp_valid = ($urandom_range(0, 199) == 0);
            vfu_resp_data = $urandom();
            rst = ($urandom_range(0, 499) == 0);
            tick();
            rst = 1'b0;
        end
        drain();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
